nv_nvdla_sdp_erdma_rd_responder: RTL and testbench
==================================================

Name: nv_nvdla_sdp_erdma_rd_responder

Overview:
- Memory-side responder for the SDP ERDMA read-DMA channel, i.e. the far end of the e2mcif/e2cvif read interface.
- Accepts 79-bit read requests (64-bit address, 15-bit atom count), issues one 32B atom read per atom to a backing memory port, and packs the returned atoms into 514-bit response beats (512 data + 2-bit half mask).
- Enforces the requester's latency-FIFO credit protocol via rd_cdt_lat_fifo_pop.
- Used as the MCIF/CVIF stand-in in SDP subsystem benches and as the bridge to on-chip SRAM.

Parameters:
- CREDIT_INIT, 16, response beats the requester's latency FIFO can hold; credit counter reset value.
- CREDIT_W, 8, credit counter width; must satisfy CREDIT_INIT < 2^CREDIT_W.

Ports:
- nvdla_core_clk  in  1  core clock.
- nvdla_core_rstn  in  1  asynchronous active-low reset.
- rd_req_valid  in  1  request valid.
- rd_req_ready  out  1  request ready.
- rd_req_pd  in  79  [63:0] byte address (32B aligned), [78:64] size = atoms-1.
- rd_rsp_valid  out  1  response beat valid.
- rd_rsp_ready  in  1  response beat ready.
- rd_rsp_pd  out  514  [511:0] data, [513:512] mask (bit0 = low 256b valid, bit1 = high 256b valid).
- rd_cdt_lat_fifo_pop  in  1  one-cycle pulse, returns one credit.
- mem_rd_req_valid  out  1  atom read valid.
- mem_rd_req_ready  in  1  atom read ready.
- mem_rd_req_addr  out  64  atom byte address, [4:0]=0.
- mem_rd_rsp_valid  in  1  atom data valid (in-order).
- mem_rd_rsp_ready  out  1  atom data ready.
- mem_rd_rsp_data  in  256  atom data.
- busy  out  1  request in progress.
- credit_err  out  1  sticky: pop received with counter already at CREDIT_INIT.

Behaviour:
- Reset values: rd_req_ready=0 for one cycle after reset deassert then 1; rd_rsp_valid=0; rd_rsp_pd=0; mem_rd_req_valid=0; mem_rd_req_addr=0; mem_rd_rsp_ready=0; busy=0; credit_err=0; credit counter=CREDIT_INIT. Async reset mid-request discards all state, with no partial beat emitted.
- FSM IDLE -> ISSUE -> DRAIN -> IDLE.
- IDLE: rd_req_ready=1. Handshake latches addr with [4:0] forced to 0, sets atoms_total=size+1 (16-bit), clears counters, sets busy=1, enters ISSUE.
- ISSUE: mem_rd_req_valid=1, mem_rd_req_addr = base + 32*issued. Address arithmetic is 64-bit and wraps modulo 2^64. On each handshake issued++; after the last atom, go to DRAIN.
- DRAIN: wait until atoms returned == atoms_total and the final beat has handshaked, then go to IDLE with busy=0. rd_req_ready=0 in ISSUE and DRAIN.
- Response assembly runs concurrently with ISSUE and DRAIN:
  - For returned atom k, half h = bit5 of (base + 32*k). Write data to half h and set mask[h].
  - The beat closes when h==1 or k is the last atom. Example: a first atom at a high half gives mask 2'b10; a last atom at a low half gives mask 2'b01.
  - mem_rd_rsp_ready = !beat_full. This leaves one bubble cycle per beat, which is accepted.
- Output:
  - rd_rsp_valid = beat_full && credit>0. Credit only rises while a beat waits, so valid never drops before the handshake.
  - rd_rsp_pd holds stable while valid && !ready.
  - On handshake: beat_full=0, mask cleared, credit decrements.
  - Unused half data is zero.
- Credit counter:
  - +1 on pop, -1 on beat handshake. Both in the same cycle leaves it unchanged.
  - Pop at CREDIT_INIT with no handshake that cycle: counter saturates and credit_err is set. credit_err clears only on reset.
- Latency: request handshake to first mem_rd_req_valid is 1 cycle. The last atom accepted makes rd_rsp_valid assert the next cycle if credit>0.
- size=0: single atom, single beat.

Test Plan:
- Aligned: addr 0x1000, size 3, memory returns atoms A0..A3 -> 2 beats {A1,A0} then {A3,A2}, mask 2'b11 each; credit 16 -> 14; busy drops after beat 2.
- Misaligned: addr 0x1020, size 2 -> beats {A0 high, mask 2'b10}, then {A2,A1} mask 2'b11; issued addrs 0x1020, 0x1040, 0x1060.
- Credit stall: CREDIT_INIT=2, no pops, size 7 -> exactly 2 beats sent, rd_rsp_valid held 0 and pd stable. Single pop -> third beat issued the next cycle.
- Backpressure: rd_rsp_ready low for 10 cycles with mem_rd_rsp_valid held high -> mem_rd_rsp_ready=0, beat data and mask unchanged, no atom lost. Same-cycle pop plus handshake leaves credit unchanged.
- Wrap and error: addr 0xFFFF_FFFF_FFFF_FFE0, size 1 -> second atom addr 0x0. Pop with credit=CREDIT_INIT -> credit_err=1, counter stays at CREDIT_INIT.
- Reset mid-request after 1 of 4 atoms returned -> all outputs at reset values; a new request afterwards completes normally.

Source files
------------

// File: rtl/nv_nvdla_sdp_erdma_rd_responder.sv
// Memory-side responder for the SDP ERDMA read channel.
// Splits requests into 32B atom reads and packs atoms into 64B beats.
module nv_nvdla_sdp_erdma_rd_responder #(
  parameter int CREDIT_INIT = 16,
  parameter int CREDIT_W    = 8
) (
  input  logic         nvdla_core_clk,
  input  logic         nvdla_core_rstn,
  input  logic         rd_req_valid,
  output logic         rd_req_ready,
  input  logic [78:0]  rd_req_pd,
  output logic         rd_rsp_valid,
  input  logic         rd_rsp_ready,
  output logic [513:0] rd_rsp_pd,
  input  logic         rd_cdt_lat_fifo_pop,
  output logic         mem_rd_req_valid,
  input  logic         mem_rd_req_ready,
  output logic [63:0]  mem_rd_req_addr,
  input  logic         mem_rd_rsp_valid,
  output logic         mem_rd_rsp_ready,
  input  logic [255:0] mem_rd_rsp_data,
  output logic         busy,
  output logic         credit_err
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  localparam logic [CREDIT_W-1:0] CMAX = CREDIT_W'(CREDIT_INIT);
  localparam logic [CREDIT_W-1:0] CONE = CREDIT_W'(1);

  state_t state, state_nxt;

  logic                started;
  logic [63:0]         base;
  logic [15:0]         total;
  logic [15:0]         issued;
  logic [15:0]         returned;
  logic [511:0]        data;
  logic [1:0]          mask;
  logic                full;
  logic [CREDIT_W-1:0] credit;

  logic req_hs;
  logic mreq_hs;
  logic mrsp_hs;
  logic rsp_hs;
  logic half;
  logic last_atom;
  logic last_issue;
  logic unused_addr_lsb;

  assign req_hs  = rd_req_valid && rd_req_ready;
  assign mreq_hs = mem_rd_req_valid && mem_rd_req_ready;
  assign mrsp_hs = mem_rd_rsp_valid && mem_rd_rsp_ready;
  assign rsp_hs  = rd_rsp_valid && rd_rsp_ready;

  // base is 32B aligned, so bit5 of base+32k is base[5]^k[0]
  assign half       = base[5] ^ returned[0];
  assign last_atom  = (returned + 16'd1) == total;
  assign last_issue = (issued + 16'd1) == total;

  assign unused_addr_lsb = ^rd_req_pd[4:0];

  assign busy             = state != IDLE;
  assign rd_req_ready     = started && (state == IDLE);
  assign mem_rd_req_valid = state == ISSUE;
  assign mem_rd_req_addr  = mem_rd_req_valid
                          ? base + {43'd0, issued, 5'd0}
                          : 64'd0;
  assign mem_rd_rsp_ready = busy && !full && (returned != total);
  assign rd_rsp_valid     = full && (credit != '0);
  assign rd_rsp_pd        = {mask, data};

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req_hs) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (mreq_hs && last_issue) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (returned == total && (!full || rsp_hs))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state    <= IDLE;
      started  <= 1'b0;
      base     <= '0;
      total    <= '0;
      issued   <= '0;
      returned <= '0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
      if (req_hs) begin
        base     <= {rd_req_pd[63:5], 5'd0};
        total    <= {1'b0, rd_req_pd[78:64]} + 16'd1;
        issued   <= '0;
        returned <= '0;
      end else begin
        if (mreq_hs) issued <= issued + 16'd1;
        if (mrsp_hs) returned <= returned + 16'd1;
      end
    end
  end

  // a beat closes on a high half or on the final atom
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      data <= '0;
      mask <= '0;
      full <= 1'b0;
    end else if (rsp_hs) begin
      data <= '0;
      mask <= '0;
      full <= 1'b0;
    end else if (mrsp_hs) begin
      if (half) begin
        data[511:256] <= mem_rd_rsp_data;
        mask[1]       <= 1'b1;
      end else begin
        data[255:0] <= mem_rd_rsp_data;
        mask[0]     <= 1'b1;
      end
      full <= half || last_atom;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      credit     <= CMAX;
      credit_err <= 1'b0;
    end else if (rd_cdt_lat_fifo_pop && !rsp_hs) begin
      if (credit == CMAX) credit_err <= 1'b1;
      else credit <= credit + CONE;
    end else if (rsp_hs && !rd_cdt_lat_fifo_pop) begin
      credit <= credit - CONE;
    end
  end

endmodule

// File: tb/tb_nv_nvdla_sdp_erdma_rd_responder.sv
// Randomized bench for the ERDMA read responder.
// A queue memory and beat model predict every address and beat.
module tb_nv_nvdla_sdp_erdma_rd_responder;

  localparam int INIT = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rd_req_valid = 1'b0;
  logic         rd_req_ready;
  logic [78:0]  rd_req_pd = '0;
  logic         rd_rsp_valid;
  logic         rd_rsp_ready = 1'b0;
  logic [513:0] rd_rsp_pd;
  logic         rd_cdt_lat_fifo_pop = 1'b0;
  logic         mem_rd_req_valid;
  logic         mem_rd_req_ready = 1'b0;
  logic [63:0]  mem_rd_req_addr;
  logic         mem_rd_rsp_valid = 1'b0;
  logic         mem_rd_rsp_ready;
  logic [255:0] mem_rd_rsp_data = '0;
  logic         busy;
  logic         credit_err;

  nv_nvdla_sdp_erdma_rd_responder #(
    .CREDIT_INIT(INIT),
    .CREDIT_W(8)
  ) dut (
    .nvdla_core_clk(clk),
    .nvdla_core_rstn(rst_n),
    .rd_req_valid(rd_req_valid),
    .rd_req_ready(rd_req_ready),
    .rd_req_pd(rd_req_pd),
    .rd_rsp_valid(rd_rsp_valid),
    .rd_rsp_ready(rd_rsp_ready),
    .rd_rsp_pd(rd_rsp_pd),
    .rd_cdt_lat_fifo_pop(rd_cdt_lat_fifo_pop),
    .mem_rd_req_valid(mem_rd_req_valid),
    .mem_rd_req_ready(mem_rd_req_ready),
    .mem_rd_req_addr(mem_rd_req_addr),
    .mem_rd_rsp_valid(mem_rd_rsp_valid),
    .mem_rd_rsp_ready(mem_rd_rsp_ready),
    .mem_rd_rsp_data(mem_rd_rsp_data),
    .busy(busy),
    .credit_err(credit_err)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  int total_chk = 0;
  int passed = 0;

  logic [63:0]  exp_addr[$];
  logic [63:0]  mq[$];
  logic [513:0] exp_beats[$];

  int  m_credit = INIT;
  bit  m_err = 0;
  int  cur_n = 0;
  int  atoms_ret = 0;
  int  beats_got = 0;
  bit  want_valid = 0;
  bit  chk_lat = 0;
  bit  pv = 0;
  bit  pr = 0;
  logic [513:0] ppd = '0;
  bit  req_go = 0;
  logic [78:0] req_pd = '0;
  int  rsp_mode = 0;
  int  pop_mode = 0;
  bit  pop_once = 0;
  bit  mreq_force = 0;
  bit  mrsp_force = 0;

  task automatic chk(input string tag, input logic [513:0] obs,
                     input logic [513:0] exp);
    total_chk++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic logic [255:0] mem_data(input logic [63:0] a);
    return {a ^ 64'hDEAD_BEEF_0123_4567, ~a,
            a + 64'h1111, {a[31:0], a[63:32]}};
  endfunction

  // spec-level model: atom k lives at base+32k, half = bit5 of that address
  task automatic expect_req(input logic [63:0] addr, input int n);
    logic [63:0]  b;
    logic [63:0]  a;
    logic [511:0] d;
    logic [1:0]   m;
    b = {addr[63:5], 5'd0};
    d = '0;
    m = '0;
    for (int k = 0; k < n; k++) begin
      a = b + 64'(k) * 64'd32;
      exp_addr.push_back(a);
      if (a[5]) begin
        d[511:256] = mem_data(a);
        m[1] = 1'b1;
      end else begin
        d[255:0] = mem_data(a);
        m[0] = 1'b1;
      end
      if (a[5] || k == n - 1) begin
        exp_beats.push_back({m, d});
        d = '0;
        m = '0;
      end
    end
    cur_n = n;
    atoms_ret = 0;
  endtask

  task automatic step();
    bit pop, hs_rsp, hs_mreq, hs_mrsp;
    @(negedge clk);
    if (want_valid) chk("valid_expected", rd_rsp_valid, 1'b1);
    want_valid = 0;
    if (chk_lat) begin
      chk("issue_latency", mem_rd_req_valid, 1'b1);
      chk("busy_set", busy, 1'b1);
    end
    chk_lat = 0;
    if (pv && !pr) begin
      chk("valid_hold", rd_rsp_valid, 1'b1);
      chk("pd_hold", rd_rsp_pd, ppd);
    end
    if (m_credit == 0) chk("no_credit", rd_rsp_valid, 1'b0);
    if (rd_rsp_valid) chk("mem_rdy_full", mem_rd_rsp_ready, 1'b0);
    chk("credit_err", credit_err, m_err);

    rd_req_valid = req_go;
    rd_req_pd = req_go ? req_pd : '0;
    rd_rsp_ready = (rsp_mode == 2) ||
                   (rsp_mode == 0 && $urandom_range(0, 3) != 0);
    mem_rd_req_ready = mreq_force || ($urandom_range(0, 2) != 0);
    mem_rd_rsp_valid = (mq.size() > 0) &&
                       (mrsp_force || $urandom_range(0, 2) != 0);
    mem_rd_rsp_data = mem_rd_rsp_valid ? mem_data(mq[0]) : '0;
    pop = pop_once ||
          (pop_mode == 0 && m_credit < INIT && $urandom_range(0, 2) == 0);
    pop_once = 0;
    rd_cdt_lat_fifo_pop = pop;

    hs_rsp  = rd_rsp_valid && rd_rsp_ready;
    hs_mreq = mem_rd_req_valid && mem_rd_req_ready;
    hs_mrsp = mem_rd_rsp_valid && mem_rd_rsp_ready;

    if (req_go && rd_req_ready) begin
      expect_req(req_pd[63:0], int'(req_pd[78:64]) + 1);
      req_go = 0;
      chk_lat = 1;
    end
    if (hs_mreq) begin
      chk("addr_avail", exp_addr.size() > 0, 1'b1);
      if (exp_addr.size() > 0)
        chk("mem_addr", mem_rd_req_addr, exp_addr.pop_front());
      mq.push_back(mem_rd_req_addr);
    end
    if (hs_mrsp) begin
      void'(mq.pop_front());
      atoms_ret++;
    end
    if (hs_rsp) begin
      chk("beat_avail", exp_beats.size() > 0, 1'b1);
      if (exp_beats.size() > 0)
        chk("beat", rd_rsp_pd, exp_beats.pop_front());
      beats_got++;
    end
    if (pop && !hs_rsp) begin
      if (m_credit == INIT) m_err = 1;
      else m_credit++;
    end else if (hs_rsp && !pop) begin
      m_credit--;
    end
    if (hs_mrsp && atoms_ret == cur_n && m_credit > 0) want_valid = 1;
    pv = rd_rsp_valid;
    pr = rd_rsp_ready;
    ppd = rd_rsp_pd;
  endtask

  task automatic send_req(input logic [63:0] addr, input int size);
    req_pd = {15'(size), addr};
    req_go = 1;
  endtask

  task automatic finish_req(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((req_go || busy || exp_beats.size() > 0) && n < budget);
    chk({tag, "_idle"}, busy, 1'b0);
    chk({tag, "_beats_left"}, exp_beats.size(), 0);
    chk({tag, "_addrs_left"}, exp_addr.size(), 0);
    chk({tag, "_mem_left"}, mq.size(), 0);
  endtask

  task automatic refill();
    int n;
    n = 0;
    while (m_credit < INIT && n < 500) begin
      step();
      n++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"}, rd_req_ready, 1'b0);
    chk({tag, "_rsp_valid"}, rd_rsp_valid, 1'b0);
    chk({tag, "_rsp_pd"}, rd_rsp_pd, '0);
    chk({tag, "_mreq_valid"}, mem_rd_req_valid, 1'b0);
    chk({tag, "_mreq_addr"}, mem_rd_req_addr, '0);
    chk({tag, "_mrsp_ready"}, mem_rd_rsp_ready, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_credit_err"}, credit_err, 1'b0);
  endtask

  initial begin
    int b0;
    int n;
    logic [513:0] saved;
    logic [63:0]  ra;

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    #1;
    chk("ready_first_cycle", rd_req_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("ready_after_cycle", rd_req_ready, 1'b1);

    b0 = beats_got;
    send_req(64'h1000, 3);
    finish_req("aligned", 200);
    chk("aligned_nbeats", beats_got - b0, 2);

    b0 = beats_got;
    send_req(64'h1020, 2);
    finish_req("misaligned", 200);
    chk("misaligned_nbeats", beats_got - b0, 2);

    b0 = beats_got;
    send_req(64'hFFFF_FFFF_FFFF_FFE0, 1);
    finish_req("wrap", 200);
    chk("wrap_nbeats", beats_got - b0, 2);

    refill();
    send_req(64'h3000, 7);
    mreq_force = 1;
    mrsp_force = 1;
    rsp_mode = 1;
    n = 0;
    do begin
      step();
      n++;
    end while (!rd_rsp_valid && n < 30);
    chk("bp_valid", rd_rsp_valid, 1'b1);
    saved = rd_rsp_pd;
    repeat (10) begin
      step();
      chk("bp_pd", rd_rsp_pd, saved);
      chk("bp_mrdy", mem_rd_rsp_ready, 1'b0);
    end
    rsp_mode = 0;
    mreq_force = 0;
    mrsp_force = 0;
    finish_req("backpressure", 400);

    refill();
    pop_once = 1;
    step();
    step();
    chk("credit_err_set", credit_err, 1'b1);

    b0 = beats_got;
    send_req(64'h4000, 39);
    pop_mode = 1;
    rsp_mode = 2;
    mreq_force = 1;
    mrsp_force = 1;
    repeat (120) step();
    chk("stall_beats", beats_got - b0, 16);
    saved = rd_rsp_pd;
    repeat (5) step();
    chk("stall_pd", rd_rsp_pd, saved);
    chk("stall_valid", rd_rsp_valid, 1'b0);
    pop_once = 1;
    step();
    want_valid = 1;
    pop_once = 1;
    step();
    n = 0;
    do begin
      step();
      n++;
    end while (!rd_rsp_valid && n < 8);
    chk("pop_hs_keep", rd_rsp_valid, 1'b1);
    pop_mode = 0;
    rsp_mode = 0;
    mreq_force = 0;
    mrsp_force = 0;
    finish_req("stall", 2000);

    for (int i = 0; i < 25; i++) begin
      ra = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) ra[63:9] = '1;
      send_req(ra, $urandom_range(0, 9));
      finish_req("rand", 600);
    end

    send_req(64'h2000, 3);
    n = 0;
    do begin
      step();
      n++;
    end while (atoms_ret < 1 && n < 100);
    chk("mid_progress", atoms_ret, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    rd_req_valid = 0;
    rd_rsp_ready = 0;
    rd_cdt_lat_fifo_pop = 0;
    mem_rd_req_ready = 0;
    mem_rd_rsp_valid = 0;
    mem_rd_rsp_data = '0;
    #1;
    check_reset_vals("mid_reset");
    exp_addr.delete();
    exp_beats.delete();
    mq.delete();
    m_credit = INIT;
    m_err = 0;
    want_valid = 0;
    chk_lat = 0;
    pv = 0;
    req_go = 0;
    cur_n = 0;
    atoms_ret = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    b0 = beats_got;
    send_req(64'h205F, 4);
    finish_req("after_reset", 400);
    chk("after_reset_nbeats", beats_got - b0, 3);

    $display("%0d/%0d checks passed", passed, total_chk);
    $finish;
  end

endmodule
